// File: rtl/iq_demod_pkg.sv
// Shared encodings and defaults for the I/Q receive-side decoder.
package iq_demod_pkg;

  localparam logic PH_I = 1'b1;
  localparam logic PH_Q = 1'b0;

  localparam int unsigned WARMUP_DEF = 2;
  localparam int unsigned WARM_W     = 4;

  // Phase tag expected on the enabled cycle after a given one.
  function automatic logic ph_next(input logic ph);
    return (ph == PH_I) ? PH_Q : PH_I;
  endfunction

endpackage

// File: rtl/diff_dec_acc.sv
// Differential decoder: y = acc ^ c with an XOR accumulator when DIFF_DEC_EN is
// defined, otherwise a plain registered pass-through of the chip.
module diff_dec_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic c_i,
  input  logic en_i,
  input  logic resync_i,
  output logic y_o
);

  logic y_q, y_d;

`ifdef DIFF_DEC_EN
  logic acc_q, acc_d;

  // Resync restarts the accumulator but still lets the in-flight chip out.
  always_comb begin
    acc_d = acc_q;
    y_d   = y_q;
    if (en_i) begin
      acc_d = acc_q ^ c_i;
      y_d   = acc_q ^ c_i;
    end
    if (resync_i) begin
      acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
      y_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end
`else
  logic unused_resync;
  assign unused_resync = resync_i;

  always_comb begin
    y_d = en_i ? c_i : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end
`endif

  assign y_o = y_q;

endmodule

// File: rtl/iq_p2s_diffdec.sv
// Offset I/Q hard decisions to serial bits with differential decode, phase
// alternation monitor and warm-up gated validity. Decode enabled by DIFF_DEC_EN.
module iq_p2s_diffdec
  import iq_demod_pkg::*;
#(
  parameter int unsigned WARMUP = WARMUP_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_div2,
  input  logic             in_en,
  input  logic             b_i,
  input  logic             b_q,
  input  logic             clr_err,
  output logic             y,
  output logic             y_valid,
  output logic             phase_err,
  output logic [CNT_W-1:0] bit_cnt
);

  logic              i_q, i_d;
  logic              q_q, q_d;
  logic              en_q, en_d;
  logic              ph_last_q, ph_last_d;
  logic              ph_seen_q, ph_seen_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              y_valid_q, y_valid_d;
  logic              phase_err_q, phase_err_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              chip_c;
  logic              err_c;

  assign chip_c = i_q ^ q_q;
  assign err_c  = in_en & ph_seen_q & (clk_div2 != ph_next(ph_last_q));

  always_comb begin
    i_d         = i_q;
    q_d         = q_q;
    en_d        = in_en;
    ph_last_d   = ph_last_q;
    ph_seen_d   = ph_seen_q;
    warm_d      = warm_q;
    y_valid_d   = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    phase_err_d = err_c | (phase_err_q & ~clr_err);

    if (in_en) begin
      i_d       = b_i;
      q_d       = b_q;
      ph_last_d = clk_div2;
      ph_seen_d = 1'b1;
    end

    // Warm-up saturates at WARMUP; validity is judged on the pre-increment value.
    if (en_q) begin
      y_valid_d = (warm_q == WARM_W'(WARMUP));
      if (!y_valid_d) begin
        warm_d = warm_q + WARM_W'(1);
      end
    end

    if (err_c) begin
      warm_d = '0;
    end

    if (y_valid_d) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q         <= 1'b0;
      q_q         <= 1'b0;
      en_q        <= 1'b0;
      ph_last_q   <= 1'b0;
      ph_seen_q   <= 1'b0;
      warm_q      <= '0;
      y_valid_q   <= 1'b0;
      phase_err_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      i_q         <= i_d;
      q_q         <= q_d;
      en_q        <= en_d;
      ph_last_q   <= ph_last_d;
      ph_seen_q   <= ph_seen_d;
      warm_q      <= warm_d;
      y_valid_q   <= y_valid_d;
      phase_err_q <= phase_err_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  diff_dec_acc u_dec (
    .clk      (clk),
    .rst_n    (reset),
    .c_i      (chip_c),
    .en_i     (en_q),
    .resync_i (err_c),
    .y_o      (y)
  );

  assign y_valid   = y_valid_q;
  assign phase_err = phase_err_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_iq_p2s_diffdec.sv
// Self-checking bench for iq_p2s_diffdec: directed table, corner sequences and
// randomized traffic against a per-sample behavioural model.
module tb_iq_p2s_diffdec;

  localparam int unsigned WARMUP = 2;
  localparam int unsigned CNT_W  = 3;
`ifdef DIFF_DEC_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             clk_div2;
  logic             in_en;
  logic             b_i;
  logic             b_q;
  logic             clr_err;
  logic             y;
  logic             y_valid;
  logic             phase_err;
  logic [CNT_W-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  iq_p2s_diffdec #(.WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .clk_div2  (clk_div2),
    .in_en     (in_en),
    .b_i       (b_i),
    .b_q       (b_q),
    .clr_err   (clr_err),
    .y         (y),
    .y_valid   (y_valid),
    .phase_err (phase_err),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each accepted sample is decoded at acceptance, then delivered one edge later.
  typedef struct { bit y; bit v; } out_t;
  out_t m_pend[$];
  bit   m_seen, m_last, m_perr, m_y, m_v, m_first, m_run;
  int   m_idx, m_cnt;

  task automatic model_reset();
    m_pend.delete();
    m_seen = 0; m_last = 0; m_perr = 0; m_y = 0; m_v = 0;
    m_first = 1; m_run = 0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit en, input bit ph, input bit bi, input bit bq, input bit clr);
    bit   err, c;
    out_t o;
    if (m_pend.size() > 0) begin
      o   = m_pend.pop_front();
      m_y = o.y;
      m_v = o.v;
      if (o.v) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else begin
      m_v = 0;
    end
    err = en && m_seen && (ph == m_last);
    if (en) begin
      c = bi ^ bq;
      if (err || m_first) begin
        m_idx = 0;
        m_run = c;
      end else begin
        m_idx++;
        m_run = m_run ^ c;
      end
      m_first = 0;
      o.y = DIFF ? m_run : c;
      o.v = (m_idx >= int'(WARMUP));
      m_pend.push_back(o);
      m_last = ph;
      m_seen = 1;
    end
    m_perr = err ? 1'b1 : (clr ? 1'b0 : m_perr);
  endtask

  bit ph_cur;

  // Called away from the rising edge; returns just after the next falling edge.
  task automatic cyc(input bit en, input bit ph, input bit bi, input bit bq, input bit clr);
    in_en = en; clk_div2 = ph; b_i = bi; b_q = bq; clr_err = clr;
    @(posedge clk);
    model_edge(en, ph, bi, bq, clr);
    #1;
    chk("y", 32'(y), 32'(m_y));
    chk("y_valid", 32'(y_valid), 32'(m_v));
    chk("phase_err", 32'(phase_err), 32'(m_perr));
    chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic samp(input bit bi, input bit bq);
    ph_cur = ~ph_cur;
    cyc(1'b1, ph_cur, bi, bq, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, ph_cur, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_en = 0; clk_div2 = 0; b_i = 0; b_q = 0; clr_err = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ph_cur = 1'b0;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_phase_err", 32'(phase_err), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
  endtask

  typedef struct { bit en; bit bi; bit bq; bit ey_d; bit ey_p; bit ev; int ecnt; } vec_t;
  vec_t tbl[8];

  initial begin
    logic y_hold;
    bit   fb;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 1, 1, 1, 0, 0};
    tbl[3] = '{1, 1, 0, 1, 0, 1, 1};
    tbl[4] = '{1, 0, 1, 0, 1, 1, 2};
    tbl[5] = '{1, 0, 0, 1, 1, 1, 3};
    tbl[6] = '{0, 0, 0, 1, 0, 1, 4};
    tbl[7] = '{0, 0, 0, 1, 0, 0, 4};

    // Basic decode and warm-up
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].en) ph_cur = ~ph_cur;
      cyc(tbl[i].en, ph_cur, tbl[i].bi, tbl[i].bq, 1'b0);
      chk("tbl_y", 32'(y), 32'(DIFF ? tbl[i].ey_d : tbl[i].ey_p));
      chk("tbl_valid", 32'(y_valid), 32'(tbl[i].ev));
      chk("tbl_cnt", 32'(bit_cnt), 32'(tbl[i].ecnt));
    end

    // Phase error on repeated I tag, then resync
    do_reset();
    begin
      bit ph_seq[7]  = '{1, 0, 1, 1, 0, 1, 0};
      bit v_exp[7]   = '{0, 0, 0, 1, 0, 0, 1};
      bit pe_exp[7]  = '{0, 0, 0, 1, 1, 1, 1};
      for (int i = 0; i < 7; i++) begin
        cyc(1'b1, ph_seq[i], 1'($urandom), 1'($urandom), 1'b0);
        chk("perr_seq_valid", 32'(y_valid), 32'(v_exp[i]));
        chk("perr_seq_flag", 32'(phase_err), 32'(pe_exp[i]));
      end
      ph_cur = 1'b0;
    end

    // Clear alone, then clear racing a new error
    cyc(1'b0, ph_cur, 1'b0, 1'b0, 1'b1);
    chk("clr_alone", 32'(phase_err), 32'd0);
    samp(1'b1, 1'b0);
    cyc(1'b1, ph_cur, 1'b0, 1'b1, 1'b1);
    chk("clr_vs_err", 32'(phase_err), 32'd1);

    // Gaps after warm-up: y holds, validity follows enables
    do_reset();
    for (int i = 0; i < 4; i++) samp(1'($urandom), 1'($urandom));
    samp(1'b1, 1'b0);
    idle();
    y_hold = y;
    idle();
    chk("gap_valid", 32'(y_valid), 32'd0);
    chk("gap_hold", 32'(y), 32'(y_hold));
    samp(1'b0, 1'b1);
    chk("gap_hold2", 32'(y), 32'(y_hold));
    samp(1'b1, 1'b1);
    chk("gap_valid_back", 32'(y_valid), 32'd1);
    idle();
    idle();
    chk("gap_no_err", 32'(phase_err), 32'd0);

    // bit_cnt wrap: 9 valid outputs on a 3-bit counter
    do_reset();
    for (int i = 0; i < 11; i++) samp(1'($urandom), 1'($urandom));
    idle();
    chk("cnt_wrap", 32'(bit_cnt), 32'd1);

    // Reset mid-stream must clear outputs before the next edge
    cyc(1'b1, ph_cur, 1'b1, 1'b0, 1'b0);
    samp(1'b1, 1'b0);
    samp(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_y", 32'(y), 32'd0);
    chk("async_valid", 32'(y_valid), 32'd0);
    chk("async_perr", 32'(phase_err), 32'd0);
    chk("async_cnt", 32'(bit_cnt), 32'd0);
    model_reset();
    in_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ph_cur = 1'b0;
    for (int i = 0; i < 4; i++) samp(1'($urandom), 1'($urandom));

    // Randomized traffic with occasional phase slips and clears
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) != 0) begin
        fb = ($urandom_range(15) == 0);
        if (!fb) ph_cur = ~ph_cur;
        cyc(1'b1, ph_cur, 1'($urandom), 1'($urandom), ($urandom_range(15) == 0));
      end else begin
        cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
